pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-003 SHALL have port id_valid, input, 1, ID stage holds a real instruction.
REQ-004 SHALL have ports id_rs and id_rt, input, 3 each, ID source register addresses.
REQ-005 SHALL have ports id_uses_rs and id_uses_rt, input, 1 each, source actually read.
REQ-006 SHALL have ports id_regwrite, id_memread, input, 1 each, ID control bits.
REQ-007 SHALL have port id_dest, input, 3, ID destination register, already regdist-muxed.
REQ-008 SHALL have port br_taken, input, 1, branch resolved taken in EX.
REQ-009 SHALL have port mem_busy, input, 1, data memory not ready.
REQ-010 SHALL have ports pc_en, ifid_en, idex_en, exmem_en, output, 1 each, stage-register enables.
REQ-011 SHALL have ports ifid_flush, idex_flush, output, 1 each, load a bubble (all control bits 0).
REQ-012 SHALL have ports fwd_a and fwd_b, output, 2 each, EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB.
REQ-013 SHALL have port stall_cnt, output, 16, hazard-stall cycle count.

Function
REQ-014 SHALL keep an internal scoreboard mirroring the EX slot (valid, dest, regwrite, memread) and the MEM slot (valid, dest, regwrite), shifting only when exmem_en=1.
REQ-015 SHALL run FSM states RUN, LU_STALL, MEM_WAIT; priority mem_busy > br_taken > data hazard.
REQ-016 SHALL, when mem_busy=1, drive all enables 0 and both flushes 0, enter MEM_WAIT, and freeze scoreboard, fwd and stall_cnt.
REQ-017 SHALL leave MEM_WAIT for RUN on the first cycle with mem_busy=0, re-evaluating hazards in that cycle.
REQ-018 SHALL, on br_taken=1 without mem_busy, assert ifid_flush and idex_flush, keep pc_en=1, and load a bubble into the scoreboard EX slot; the hazard check is suppressed that cycle.
REQ-019 SHALL detect a hazard when id_valid=1 and a used source equals the dest of a valid, regwrite scoreboard slot; r0 is compared like any register.
REQ-020 SHALL, on a hazard, drive pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1 (bubble into EX).
REQ-021 SHALL otherwise drive all enables 1 and flushes 0.
REQ-022 SHALL register fwd_a/fwd_b on each ID->EX advance: 01 if the source matches the then-EX dest, else 10 if it matches the then-MEM dest, else 00; bubbles load 00.
REQ-023 SHALL increment stall_cnt in each hazard-stall cycle (not mem_busy, not flush), saturating at 16'hFFFF.

Reset
REQ-024 SHALL, while rst=1, drive pc_en, ifid_en, idex_en, exmem_en to 0 and ifid_flush, idex_flush to 1.
REQ-025 SHALL, on reset, set FSM to RUN, both scoreboard slots invalid, fwd_a=fwd_b=00 and stall_cnt=0.
REQ-026 SHALL let reset override any in-progress LU_STALL or MEM_WAIT in the same cycle.

Configuration
REQ-027 SHALL, with macro PIPE_HAZARD_FORWARD_EN defined, stall only on load-use (EX slot memread=1), exactly one cycle in LU_STALL, then forward with 10.
REQ-028 SHALL, without PIPE_HAZARD_FORWARD_EN, stall on any match against EX or MEM slot until both clear (max 2 cycles), and tie fwd_a=fwd_b=00.

Structure
REQ-029 SHALL place the FSM state enum, fwd select constants and REG_ADDR_W=3 in package pipe_ctrl_pkg.
REQ-030 SHALL implement the EX/MEM tracking as sub-module hazard_scoreboard.

Verification
REQ-031 SHALL check: forward build, load r5 then add uses r5 -> one cycle pc_en=0, idex_flush=1, then fwd_a=10, stall_cnt=1.
REQ-032 SHALL check: forward build, ALU write r3 then rs=r3 -> no stall, fwd_a=01 next cycle; no-forward build -> two stall cycles, stall_cnt=2.
REQ-033 SHALL check: br_taken=1 during a load-use hazard -> both flushes 1, pc_en=1, stall_cnt unchanged.
REQ-034 SHALL check: mem_busy high 3 cycles during LU_STALL -> all enables 0 for 3 cycles, the stall completes after release, stall_cnt rises by 1 only.
REQ-035 SHALL check: stall_cnt preloaded to 16'hFFFE via repeated stalls -> saturates at 16'hFFFF.
REQ-036 SHALL check: rst asserted mid-LU_STALL -> next cycle state RUN, fwd=00, stall_cnt=0, flushes 1 while rst held.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller and its scoreboard.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int CNT_W      = 16;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
  } mem_slot_t;

  // Observation bundle: FSM state plus both tracked slots.
  typedef struct packed {
    state_t    state;
    ex_slot_t  ex;
    mem_slot_t mem;
  } dbg_t;

  // True when a tracked slot will write register src.
  function automatic logic writes_reg(input logic                  valid,
                                      input logic                  regwrite,
                                      input logic [REG_ADDR_W-1:0] dest,
                                      input logic [REG_ADDR_W-1:0] src);
    return valid && regwrite && (dest == src);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Mirrors the EX and MEM pipeline slots; both slots shift together only when EX/MEM advances.
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_shift,
  input  logic                  i_bubble,
  input  logic                  i_id_valid,
  input  logic [REG_ADDR_W-1:0] i_id_dest,
  input  logic                  i_id_regwrite,
  input  logic                  i_id_memread,
  output ex_slot_t              o_ex,
  output mem_slot_t             o_mem
);

  ex_slot_t  r_ex;
  mem_slot_t r_mem;
  ex_slot_t  w_ex_next;

  always_comb begin
    w_ex_next = '0;
    if (!i_bubble && i_id_valid) begin
      w_ex_next.valid    = 1'b1;
      w_ex_next.dest     = i_id_dest;
      w_ex_next.regwrite = i_id_regwrite;
      w_ex_next.memread  = i_id_memread;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
    end else if (i_shift) begin
      r_mem.valid    <= r_ex.valid;
      r_mem.dest     <= r_ex.dest;
      r_mem.regwrite <= r_ex.regwrite;
      r_ex           <= w_ex_next;
    end
  end

  assign o_ex  = r_ex;
  assign o_mem = r_mem;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes and operand forwarding for a 5-stage pipe.
// Define PIPE_HAZARD_FORWARD_EN to forward results and stall only on load-use.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  br_taken,
  input  logic                  mem_busy,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  exmem_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [CNT_W-1:0]      stall_cnt,
  output dbg_t                  dbg
);

  // Handshake: the pipe has no valid/ready pairs; a stage register loads only when its
  // enable is 1, and a flush replaces the incoming contents with a bubble on that edge.

  ex_slot_t   w_ex;
  mem_slot_t  w_mem;
  logic       w_rs_ex, w_rs_mem, w_rt_ex, w_rt_mem;
  logic       w_hazard, w_stall;
  logic       w_pc_en, w_ifid_en, w_idex_en, w_exmem_en;
  logic       w_ifid_flush, w_idex_flush;
  state_t     r_state;
  logic [CNT_W-1:0] r_stall_cnt;

  hazard_scoreboard u_sb (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_shift       (w_exmem_en),
    .i_bubble      (w_idex_flush),
    .i_id_valid    (id_valid),
    .i_id_dest     (id_dest),
    .i_id_regwrite (id_regwrite),
    .i_id_memread  (id_memread),
    .o_ex          (w_ex),
    .o_mem         (w_mem)
  );

  assign w_rs_ex  = writes_reg(w_ex.valid,  w_ex.regwrite,  w_ex.dest,  id_rs);
  assign w_rt_ex  = writes_reg(w_ex.valid,  w_ex.regwrite,  w_ex.dest,  id_rt);
  assign w_rs_mem = writes_reg(w_mem.valid, w_mem.regwrite, w_mem.dest, id_rs);
  assign w_rt_mem = writes_reg(w_mem.valid, w_mem.regwrite, w_mem.dest, id_rt);

`ifdef PIPE_HAZARD_FORWARD_EN
  // Only a load still in EX cannot be forwarded in time.
  assign w_hazard = id_valid && w_ex.memread &&
                    ((id_uses_rs && w_rs_ex) || (id_uses_rt && w_rt_ex));
`else
  assign w_hazard = id_valid &&
                    ((id_uses_rs && (w_rs_ex || w_rs_mem)) ||
                     (id_uses_rt && (w_rt_ex || w_rt_mem)));
`endif

  assign w_stall = !rst && !mem_busy && !br_taken && w_hazard;

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_idex_en    = 1'b1;
    w_exmem_en   = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    if (rst) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_en    = 1'b0;
      w_exmem_en   = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (mem_busy) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
    end else if (br_taken) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
    end else if (w_hazard) begin
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else if (mem_busy) begin
      r_state <= ST_MEM_WAIT;
    end else if (w_stall) begin
      r_state <= ST_LU_STALL;
    end else begin
      r_state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

`ifdef PIPE_HAZARD_FORWARD_EN
  fwd_sel_t r_fwd_a, r_fwd_b;
  fwd_sel_t w_sel_a, w_sel_b;

  // The youngest producer (EX) wins over the older one (MEM).
  always_comb begin
    w_sel_a = FWD_RF;
    w_sel_b = FWD_RF;
    if (w_rs_ex)       w_sel_a = FWD_EXMEM;
    else if (w_rs_mem) w_sel_a = FWD_MEMWB;
    if (w_rt_ex)       w_sel_b = FWD_EXMEM;
    else if (w_rt_mem) w_sel_b = FWD_MEMWB;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_a <= FWD_RF;
      r_fwd_b <= FWD_RF;
    end else if (w_exmem_en) begin
      if (w_idex_flush || !id_valid) begin
        r_fwd_a <= FWD_RF;
        r_fwd_b <= FWD_RF;
      end else begin
        r_fwd_a <= w_sel_a;
        r_fwd_b <= w_sel_b;
      end
    end
  end

  assign fwd_a = r_fwd_a;
  assign fwd_b = r_fwd_b;
`else
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif

  assign pc_en      = w_pc_en;
  assign ifid_en    = w_ifid_en;
  assign idex_en    = w_idex_en;
  assign exmem_en   = w_exmem_en;
  assign ifid_flush = w_ifid_flush;
  assign idex_flush = w_idex_flush;
  assign stall_cnt  = r_stall_cnt;

  assign dbg.state = r_state;
  assign dbg.ex    = w_ex;
  assign dbg.mem   = w_mem;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic against a pipeline model.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_rs, id_rt, id_dest;
  logic       id_uses_rs, id_uses_rt, id_regwrite, id_memread;
  logic       br_taken, mem_busy;
  logic       pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  dbg_t       dbg;

  pipe_hazard_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_regwrite(id_regwrite),
    .id_memread (id_memread),
    .id_dest    (id_dest),
    .br_taken   (br_taken),
    .mem_busy   (mem_busy),
    .pc_en      (pc_en),
    .ifid_en    (ifid_en),
    .idex_en    (idex_en),
    .exmem_en   (exmem_en),
    .ifid_flush (ifid_flush),
    .idex_flush (idex_flush),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall_cnt  (stall_cnt),
    .dbg        (dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The pipe is two tracked instructions; each cycle is one of five outcomes.
  typedef struct { bit v; int d; bit rw; bit mr; } slot_t;
  localparam slot_t BUBBLE = '{v: 1'b0, d: 0, rw: 1'b0, mr: 1'b0};

  slot_t  m_ex  = BUBBLE;
  slot_t  m_mem = BUBBLE;
  int     m_fa = 0, m_fb = 0, m_cnt = 0;
  state_t m_state = ST_RUN;

  logic [29:0] exp_q[$];
  logic [3:0]  s_en;
  logic [1:0]  s_fl;

  function automatic bit wr(input slot_t s, input int r);
    return s.v && s.rw && (s.d == r);
  endfunction

  function automatic bit dep(input int r);
`ifdef PIPE_HAZARD_FORWARD_EN
    return wr(m_ex, r) && m_ex.mr;
`else
    return wr(m_ex, r) || wr(m_mem, r);
`endif
  endfunction

  function automatic int sel(input int r);
`ifdef PIPE_HAZARD_FORWARD_EN
    if (!id_valid)     return 0;
    if (wr(m_ex, r))   return 1;
    if (wr(m_mem, r))  return 2;
`endif
    return 0 * r;
  endfunction

  task automatic model_eval();
    bit         hz;
    logic [3:0] e_en;
    logic [1:0] e_fl;
    int         nfa, nfb;
    hz = id_valid && ((id_uses_rs && dep(int'(id_rs))) || (id_uses_rt && dep(int'(id_rt))));
    if (rst)           begin e_en = 4'b0000; e_fl = 2'b11; end
    else if (mem_busy) begin e_en = 4'b0000; e_fl = 2'b00; end
    else if (br_taken) begin e_en = 4'b1111; e_fl = 2'b11; end
    else if (hz)       begin e_en = 4'b0011; e_fl = 2'b01; end
    else               begin e_en = 4'b1111; e_fl = 2'b00; end
    exp_q.push_back({m_ex.v, m_mem.v, 2'(m_state), e_en, e_fl, 2'(m_fa), 2'(m_fb), 16'(m_cnt)});
    if (rst) begin
      m_ex = BUBBLE; m_mem = BUBBLE; m_fa = 0; m_fb = 0; m_cnt = 0; m_state = ST_RUN;
    end else if (mem_busy) begin
      m_state = ST_MEM_WAIT;
    end else if (br_taken || hz) begin
      m_mem = m_ex; m_ex = BUBBLE; m_fa = 0; m_fb = 0;
      if (!br_taken && m_cnt < 65535) m_cnt++;
      m_state = br_taken ? ST_RUN : ST_LU_STALL;
    end else begin
      nfa = sel(int'(id_rs));
      nfb = sel(int'(id_rt));
      m_fa = nfa; m_fb = nfb;
      m_mem = m_ex;
      m_ex = id_valid ? '{v: 1'b1, d: int'(id_dest), rw: id_regwrite, mr: id_memread} : BUBBLE;
      m_state = ST_RUN;
    end
  endtask

  // One clock: sample and check at the falling edge, return 1ns after the rising edge.
  task automatic cycle(input bit do_chk);
    logic [29:0] e;
    @(negedge clk);
    model_eval();
    e    = exp_q.pop_front();
    s_en = {pc_en, ifid_en, idex_en, exmem_en};
    s_fl = {ifid_flush, idex_flush};
    if (do_chk) begin
      check("enables", s_en, e[25:22]);
      check("flushes", s_fl, e[21:20]);
      check("fwd_a", fwd_a, e[19:18]);
      check("fwd_b", fwd_b, e[17:16]);
      check("stall_cnt", stall_cnt, e[15:0]);
      check("state", dbg.state, e[27:26]);
      check("ex_valid", dbg.ex.valid, e[29]);
      check("mem_valid", dbg.mem.valid, e[28]);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  task automatic set_id(input bit v, input int rs, input bit urs, input int rt, input bit urt,
                        input bit rw, input bit mr, input int dest);
    id_valid = v; id_rs = 3'(rs); id_uses_rs = urs; id_rt = 3'(rt); id_uses_rt = urt;
    id_regwrite = rw; id_memread = mr; id_dest = 3'(dest);
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    br_taken = 1'b0;
    mem_busy = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cycle(1);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst = 1'b1;
    idle();
    cycle(0);
    cycle(1);
    check("rst_en", s_en, 4'b0000);
    check("rst_flush", s_fl, 2'b11);
    check("rst_cnt", stall_cnt, 16'd0);
    check("rst_fwd_a", fwd_a, 2'b00);
    rst = 1'b0;

    // load r5 followed by a use of r5
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1, 5);
    cycle(1);
    set_id(1, 5, 1, 0, 0, 1, 0, 6);
    cycle(1);
    check("lu_pc_en", s_en[3], 1'b0);
    check("lu_idex_flush", s_fl[0], 1'b1);
`ifdef PIPE_HAZARD_FORWARD_EN
    cycle(1);
    check("lu_adv_pc_en", s_en[3], 1'b1);
    check("lu_fwd_a", fwd_a, 2'b10);
    check("lu_cnt", stall_cnt, 16'd1);
`else
    cycle(1);
    check("lu_stall2_pc_en", s_en[3], 1'b0);
    cycle(1);
    check("lu_adv_pc_en", s_en[3], 1'b1);
    check("lu_fwd_a", fwd_a, 2'b00);
    check("lu_cnt", stall_cnt, 16'd2);
`endif

    // ALU write r3 followed by a use of r3
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 0, 3);
    cycle(1);
    set_id(1, 3, 1, 0, 0, 1, 0, 4);
`ifdef PIPE_HAZARD_FORWARD_EN
    cycle(1);
    check("alu_pc_en", s_en[3], 1'b1);
    check("alu_fwd_a", fwd_a, 2'b01);
    check("alu_cnt", stall_cnt, 16'd0);
`else
    cycle(1);
    check("alu_stall1_pc_en", s_en[3], 1'b0);
    cycle(1);
    check("alu_stall2_pc_en", s_en[3], 1'b0);
    cycle(1);
    check("alu_adv_pc_en", s_en[3], 1'b1);
    check("alu_cnt", stall_cnt, 16'd2);
`endif

    // branch taken while a load-use hazard is present
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1, 5);
    cycle(1);
    set_id(1, 5, 1, 0, 0, 1, 0, 6);
    br_taken = 1'b1;
    cycle(1);
    check("br_flush", s_fl, 2'b11);
    check("br_pc_en", s_en[3], 1'b1);
    check("br_cnt", stall_cnt, 16'd0);
    br_taken = 1'b0;
    idle();
    cycle(1);
    cycle(1);

    // memory busy for three cycles on top of a load-use hazard
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1, 5);
    cycle(1);
    set_id(1, 5, 1, 0, 0, 1, 0, 6);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(1);
      check("busy_en", s_en, 4'b0000);
      check("busy_flush", s_fl, 2'b00);
      check("busy_cnt", stall_cnt, 16'd0);
      check("busy_state", dbg.state, ST_MEM_WAIT);
    end
    mem_busy = 1'b0;
    cycle(1);
    check("busy_rel_pc_en", s_en[3], 1'b0);
`ifdef PIPE_HAZARD_FORWARD_EN
    cycle(1);
    check("busy_done_pc_en", s_en[3], 1'b1);
    check("busy_done_cnt", stall_cnt, 16'd1);
    check("busy_done_fwd_a", fwd_a, 2'b10);
`else
    cycle(1);
    cycle(1);
    check("busy_done_pc_en", s_en[3], 1'b1);
    check("busy_done_cnt", stall_cnt, 16'd2);
`endif

    // reset in the middle of a load-use stall
    do_reset();
    set_id(1, 0, 0, 0, 0, 1, 1, 5);
    cycle(1);
    set_id(1, 5, 1, 0, 0, 1, 0, 6);
    cycle(1);
    check("rs_pre_state", dbg.state, ST_LU_STALL);
    rst = 1'b1;
    cycle(1);
    check("rs_flush", s_fl, 2'b11);
    check("rs_en", s_en, 4'b0000);
    check("rs_state", dbg.state, ST_RUN);
    check("rs_fwd_a", fwd_a, 2'b00);
    check("rs_cnt", stall_cnt, 16'd0);
    cycle(1);
    check("rs_flush_hold", s_fl, 2'b11);
    rst = 1'b0;
    idle();

    // saturation: an instruction chain where each one depends on its predecessor
    do_reset();
    set_id(1, 1, 1, 0, 0, 1, 1, 1);
    n = 0;
    while (m_cnt < 16'hFFFE && n < 200000) begin
      cycle(0);
      n++;
    end
    check("sat_pre", stall_cnt, 16'hFFFE);
    for (int i = 0; i < 6; i++) cycle(1);
    check("sat_hold", stall_cnt, 16'hFFFF);

    // random traffic
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst         = ($urandom_range(0, 63) == 0);
      mem_busy    = ($urandom_range(0, 7) == 0);
      br_taken    = ($urandom_range(0, 9) == 0);
      id_valid    = ($urandom_range(0, 7) != 0);
      id_rs       = 3'($urandom_range(0, 3));
      id_rt       = 3'($urandom_range(0, 3));
      id_dest     = 3'($urandom_range(0, 3));
      id_uses_rs  = 1'($urandom_range(0, 1));
      id_uses_rt  = 1'($urandom_range(0, 1));
      id_regwrite = ($urandom_range(0, 3) != 0);
      id_memread  = 1'($urandom_range(0, 1));
      cycle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
